// File: rtl/song_pkg.sv
// song_pkg: shared widths, field constants and sequencer states for song_reader
package song_pkg;
    localparam int ADDR_W = 7;
    localparam int SONG_W = 2;
    localparam int IDX_W  = ADDR_W - SONG_W;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam logic [NOTE_W-1:0] REST_NOTE = '0;
    localparam logic [DUR_W-1:0]  END_DUR   = '0;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, EMIT, HOLD, END} state_t;
endpackage

// File: rtl/song_reader.sv
// song_reader: walks one song of the ROM, hands each note to the player and flags end of song
module song_reader
    import song_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    play,
    input  logic [SONG_W-1:0]       song,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_dout,
    output logic                    new_note,
    output logic [NOTE_W-1:0]       note,
    output logic [DUR_W-1:0]        duration,
    input  logic                    note_done,
    output logic                    song_done,
    output logic                    busy
);
    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_inc;
    logic [SONG_W-1:0] song_lat;
    logic              change, last, is_end;

    assign change  = (state != IDLE) && (song != song_lat);
    assign last    = idx == '1;
    assign idx_inc = idx + 1'b1;
    assign is_end  = rom_dout[DUR_W-1:0] == END_DUR;
    assign busy    = state != IDLE;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next state and pulse outputs; a song change overrides everything
    always_comb begin
        state_nxt = state;
        new_note  = 1'b0;
        song_done = 1'b0;
        if (change) state_nxt = IDLE;
        else begin
            case (state)
                IDLE: if (play) state_nxt = ADDR;
                ADDR: state_nxt = DATA;
                DATA: state_nxt = is_end ? END : EMIT;
                EMIT: if (play) begin
                    new_note  = 1'b1;
                    state_nxt = HOLD;
                end
                HOLD: if (note_done) state_nxt = last ? END : ADDR;
                END: begin
                    song_done = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // index, song latch, ROM address and captured note fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            song_lat <= '0;
            rom_addr <= '0;
            note     <= REST_NOTE;
            duration <= '0;
        end else begin
            if (change) idx <= '0;
            else if (state == IDLE && play) begin
                song_lat <= song;
                idx      <= '0;
                rom_addr <= {song, {IDX_W{1'b0}}};
            end else if (state == HOLD && note_done && !last) begin
                idx      <= idx_inc;
                rom_addr <= {song_lat, idx_inc};
            end
            if (state == DATA && !is_end && !change) begin
                note     <= rom_dout[NOTE_W+DUR_W-1:DUR_W];
                duration <= rom_dout[DUR_W-1:0];
            end
        end
    end
endmodule
